// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-requester arbiter in front of a single shared Sysbus. Port 0 is the
// instruction requester and port 1 is the data requester. One transaction
// owns the bus from grant to its final response beat:
//
//   IDLE -> REQ  : a requester is registered as owner (1-cycle grant latency)
//   REQ  -> RESP : the Sysbus acknowledges the owner's request
//   REQ  -> IDLE : the owner withdrew its request before acknowledge
//   RESP -> IDLE : the BEATS-th response beat has been handshaken
//
// The request path and the response path are combinational pass-throughs
// from/to the current owner. The non-owner only ever sees zeros.
//
// Configuration macro:
//   BUS_ARB_FIXED_PRIO_EN  defined   -> port 0 wins simultaneous requests
//                          undefined -> round-robin against last_owner
//
// Parameters:
//   BUS_DATA_WIDTH  address / response data width (default 64)
//   BUS_TAG_WIDTH   tag width (default 13)
//   BEATS           response beats per transaction, 1..15 (default 8)
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   pN_reqcyc/req/reqtag       requester N request (in)
//   pN_reqack                  request acknowledge to requester N (out)
//   pN_respcyc/resp/resptag    response beat to requester N (out)
//   pN_respack                 requester N beat acknowledge (in)
//   bus_reqcyc/req/reqtag      shared Sysbus request (out)
//   bus_reqack                 Sysbus request acknowledge (in)
//   bus_respcyc/resp/resptag   Sysbus response beat (in)
//   bus_respack                Sysbus beat acknowledge (out)
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      p0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p0_reqtag,
    output logic                      p0_reqack,
    output logic                      p0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p0_resptag,
    input  logic                      p0_respack,

    input  logic                      p1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p1_reqtag,
    output logic                      p1_reqack,
    output logic                      p1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p1_resptag,
    input  logic                      p1_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       owner_nxt;
    logic [3:0] beat_cnt;
    logic [3:0] beat_cnt_nxt;

`ifndef BUS_ARB_FIXED_PRIO_EN
    logic       last_owner;
    logic       last_owner_nxt;
`endif

    logic       grant;
    logic       owner_reqcyc;
    logic       owner_respack;
    logic       beat_done;
    logic       last_beat;

    // Port that would be registered as owner if the FSM leaves IDLE now.
    // A lone requester always wins; only a tie consults the policy.
`ifdef BUS_ARB_FIXED_PRIO_EN
    assign grant = ~p0_reqcyc;
`else
    assign grant = (p0_reqcyc && p1_reqcyc) ? ~last_owner : ~p0_reqcyc;
`endif

    assign owner_reqcyc  = owner ? p1_reqcyc  : p0_reqcyc;
    assign owner_respack = owner ? p1_respack : p0_respack;

    // A response beat only counts while a transaction is in RESP; any
    // bus_respcyc seen in another state is ignored.
    assign beat_done = (state == RESP) && bus_respcyc && owner_respack;
    assign last_beat = (beat_cnt == 4'(BEATS - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            beat_cnt   <= 4'd0;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_owner <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
`ifndef BUS_ARB_FIXED_PRIO_EN
            last_owner <= last_owner_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and output routing
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        beat_cnt_nxt   = beat_cnt;
`ifndef BUS_ARB_FIXED_PRIO_EN
        last_owner_nxt = last_owner;
`endif

        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        p0_reqack   = 1'b0;
        p0_respcyc  = 1'b0;
        p0_resp     = '0;
        p0_resptag  = '0;
        p1_reqack   = 1'b0;
        p1_respcyc  = 1'b0;
        p1_resp     = '0;
        p1_resptag  = '0;

        unique case (state)
            IDLE: begin
                if (p0_reqcyc || p1_reqcyc) begin
                    state_nxt = REQ;
                    owner_nxt = grant;
                end
            end

            REQ: begin
                bus_reqcyc = 1'b1;
                if (owner) begin
                    bus_req    = p1_req;
                    bus_reqtag = p1_reqtag;
                    p1_reqack  = bus_reqack;
                end else begin
                    bus_req    = p0_req;
                    bus_reqtag = p0_reqtag;
                    p0_reqack  = bus_reqack;
                end

                // An acknowledge in the same cycle as a withdrawal still
                // commits the transaction: the Sysbus has already taken it.
                if (bus_reqack) begin
                    state_nxt    = RESP;
                    beat_cnt_nxt = 4'd0;
                end else if (!owner_reqcyc) begin
                    state_nxt = IDLE;
                end
            end

            RESP: begin
                bus_respack = beat_done;
                if (owner) begin
                    p1_respcyc = bus_respcyc;
                    p1_resp    = bus_resp;
                    p1_resptag = bus_resptag;
                end else begin
                    p0_respcyc = bus_respcyc;
                    p0_resp    = bus_resp;
                    p0_resptag = bus_resptag;
                end

                if (beat_done) begin
                    if (last_beat) begin
                        state_nxt      = IDLE;
                        beat_cnt_nxt   = 4'd0;
`ifndef BUS_ARB_FIXED_PRIO_EN
                        last_owner_nxt = owner;
`endif
                    end else begin
                        beat_cnt_nxt = beat_cnt + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed sequence followed by randomized transactions. The reference model
// is transaction level: it only remembers which port completed the last
// transaction and applies the arbitration rule to pick the next winner;
// every cycle the routed values are compared against what the bench drove.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk;
    logic          reset;

    logic          p0_reqcyc;
    logic [DW-1:0] p0_req;
    logic [TW-1:0] p0_reqtag;
    logic          p0_reqack;
    logic          p0_respcyc;
    logic [DW-1:0] p0_resp;
    logic [TW-1:0] p0_resptag;
    logic          p0_respack;

    logic          p1_reqcyc;
    logic [DW-1:0] p1_req;
    logic [TW-1:0] p1_reqtag;
    logic          p1_reqack;
    logic          p1_respcyc;
    logic [DW-1:0] p1_resp;
    logic [TW-1:0] p1_resptag;
    logic          p1_respack;

    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int n_tests = 0;
    int n_fail  = 0;
    int m_last  = 1;   // port that completed the most recent transaction

    bus_arbiter #(
        .BUS_DATA_WIDTH(DW),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (BEATS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p0_reqcyc  (p0_reqcyc),
        .p0_req     (p0_req),
        .p0_reqtag  (p0_reqtag),
        .p0_reqack  (p0_reqack),
        .p0_respcyc (p0_respcyc),
        .p0_resp    (p0_resp),
        .p0_resptag (p0_resptag),
        .p0_respack (p0_respack),
        .p1_reqcyc  (p1_reqcyc),
        .p1_req     (p1_req),
        .p1_reqtag  (p1_reqtag),
        .p1_reqack  (p1_reqack),
        .p1_respcyc (p1_respcyc),
        .p1_resp    (p1_resp),
        .p1_resptag (p1_resptag),
        .p1_respack (p1_respack),
        .bus_reqcyc (bus_reqcyc),
        .bus_req    (bus_req),
        .bus_reqtag (bus_reqtag),
        .bus_reqack (bus_reqack),
        .bus_respcyc(bus_respcyc),
        .bus_resp   (bus_resp),
        .bus_resptag(bus_resptag),
        .bus_respack(bus_respack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner chosen by the arbitration rule for the given request levels.
    function automatic int model_grant(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
`ifdef BUS_ARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - m_last;
`endif
    endfunction

    function automatic logic [DW-1:0] req_of(input int p);
        return (p == 1) ? p1_req : p0_req;
    endfunction
    function automatic logic [TW-1:0] reqtag_of(input int p);
        return (p == 1) ? p1_reqtag : p0_reqtag;
    endfunction
    function automatic logic reqack_of(input int p);
        return (p == 1) ? p1_reqack : p0_reqack;
    endfunction
    function automatic logic respcyc_of(input int p);
        return (p == 1) ? p1_respcyc : p0_respcyc;
    endfunction
    function automatic logic [DW-1:0] resp_of(input int p);
        return (p == 1) ? p1_resp : p0_resp;
    endfunction
    function automatic logic [TW-1:0] resptag_of(input int p);
        return (p == 1) ? p1_resptag : p0_resptag;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int p);
        if (p == 1) begin
            p1_req    = {$urandom, $urandom};
            p1_reqtag = 13'($urandom);
            p1_reqcyc = 1'b1;
        end else begin
            p0_req    = {$urandom, $urandom};
            p0_reqtag = 13'($urandom);
            p0_reqcyc = 1'b1;
        end
    endtask

    task automatic lower(input int p);
        if (p == 1) p1_reqcyc = 1'b0;
        else        p0_reqcyc = 1'b0;
    endtask

    task automatic set_respack(input int p, input logic v);
        if (p == 1) p1_respack = v;
        else        p0_respack = v;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_bus"}, 128'({bus_req, bus_reqtag, bus_reqcyc, bus_respack}), 128'(0));
        chk({tag, "_p0"},  128'({p0_resp, p0_resptag, p0_reqack, p0_respcyc}), 128'(0));
        chk({tag, "_p1"},  128'({p1_resp, p1_resptag, p1_reqack, p1_respcyc}), 128'(0));
    endtask

    // Entry: just after a rising edge, arbiter idle, winner w's request up.
    // Returns just after the edge that completes the last beat (or after
    // a reset abort when abort_beat >= 0).
    task automatic serve(input int w, input int ack_dly, input int stall_beat,
                         input int stall_len, input int abort_beat);
        int            o;
        int            b;
        int            cyc;
        int            stalled;
        logic          stalling;
        logic          v;
        logic          a;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        o       = 1 - w;
        b       = 0;
        cyc     = 0;
        stalled = 0;

        // Idle cycle: stray response beats must be ignored.
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        set_respack(0, 1'b1);
        set_respack(1, 1'b1);
        @(negedge clk);
        chk("idle_bus_reqcyc",  128'(bus_reqcyc),  128'(0));
        chk("idle_bus_respack", 128'(bus_respack), 128'(0));
        chk("idle_respcyc",     128'({p0_respcyc, p1_respcyc}), 128'(0));
        step();

        for (int i = 0; i <= ack_dly; i++) begin
            bus_reqack  = (i == ack_dly);
            bus_respcyc = 1'($urandom_range(1));
            @(negedge clk);
            chk("req_bus_reqcyc",    128'(bus_reqcyc),      128'(1));
            chk("req_addr",          128'(bus_req),         128'(req_of(w)));
            chk("req_tag",           128'(bus_reqtag),      128'(reqtag_of(w)));
            chk("req_owner_ack",     128'(reqack_of(w)),    128'(i == ack_dly));
            chk("req_other_ack",     128'(reqack_of(o)),    128'(0));
            chk("req_bus_respack",   128'(bus_respack),     128'(0));
            chk("req_owner_respcyc", 128'(respcyc_of(w)),   128'(0));
            step();
        end
        bus_reqack = 1'b0;
        lower(w);

        while (b < BEATS) begin
            if (cyc > 200) begin
                chk("beat_budget", 128'(b), 128'(BEATS));
                break;
            end
            if (b == abort_beat) begin
                bus_respcyc = 1'b1;
                set_respack(w, 1'b1);
                reset = 1'b0;
                #1;
                chk_quiet("abort");
                repeat (2) @(posedge clk);
                #1;
                reset       = 1'b1;
                bus_respcyc = 1'b0;
                set_respack(0, 1'b0);
                set_respack(1, 1'b0);
                m_last = 1;
                return;
            end
            stalling = (b == stall_beat) && (stalled < stall_len);
            if (stalling) stalled++;
            v           = stalling ? 1'b1 : ($urandom_range(3) != 0);
            a           = !stalling;
            d           = {$urandom, $urandom};
            t           = 13'($urandom);
            bus_respcyc = v;
            bus_resp    = d;
            bus_resptag = t;
            set_respack(w, a);
            set_respack(o, 1'($urandom_range(1)));
            @(negedge clk);
            chk("resp_owner_cyc",   128'(respcyc_of(w)), 128'(v));
            chk("resp_owner_data",  128'(resp_of(w)),    128'(d));
            chk("resp_owner_tag",   128'(resptag_of(w)), 128'(t));
            chk("resp_other_cyc",   128'(respcyc_of(o)), 128'(0));
            chk("resp_other_data",  128'({resp_of(o), resptag_of(o)}), 128'(0));
            chk("resp_other_ack",   128'(reqack_of(o)),  128'(0));
            chk("resp_bus_respack", 128'(bus_respack),   128'(v && a));
            chk("resp_bus_reqcyc",  128'(bus_reqcyc),    128'(0));
            if (v && a) b++;
            cyc++;
            step();
        end
        bus_respcyc = 1'b0;
        set_respack(0, 1'b0);
        set_respack(1, 1'b0);
        m_last = w;
    endtask

    task automatic drain();
        while (p0_reqcyc || p1_reqcyc)
            serve(model_grant(p0_reqcyc, p1_reqcyc), int'($urandom_range(2)), -1, 0, -1);
    endtask

    initial begin
        // Reset with busy inputs: every output must stay at zero.
        reset       = 1'b0;
        p0_reqcyc   = 1'b1;
        p0_req      = {$urandom, $urandom};
        p0_reqtag   = 13'($urandom);
        p0_respack  = 1'b1;
        p1_reqcyc   = 1'b1;
        p1_req      = {$urandom, $urandom};
        p1_reqtag   = 13'($urandom);
        p1_respack  = 1'b1;
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = {$urandom, $urandom};
        bus_resptag = 13'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        p0_reqcyc   = 1'b0;
        p1_reqcyc   = 1'b0;
        p0_respack  = 1'b0;
        p1_respack  = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        step();
        reset  = 1'b1;
        m_last = 1;
        step();

        // Simultaneous first request after reset, both held; then port 0
        // re-requests while port 1 is still waiting.
        raise(0);
        raise(1);
        serve(model_grant(1'b1, 1'b1), 1, -1, 0, -1);
        raise(0);
        drain();

        // Port 0 alone at address 0x1000, acknowledged on the third REQ cycle.
        step();
        p0_req    = 64'h1000;
        p0_reqtag = 13'h0a5;
        p0_reqcyc = 1'b1;
        serve(0, 2, -1, 0, -1);

        // Port 1 withdraws before acknowledge: no transaction, history kept.
        raise(1);
        @(negedge clk);
        chk("drop_idle_reqcyc", 128'(bus_reqcyc), 128'(0));
        step();
        @(negedge clk);
        chk("drop_req_reqcyc", 128'(bus_reqcyc), 128'(1));
        chk("drop_req_ack",    128'(p1_reqack),  128'(0));
        step();
        lower(1);
        @(negedge clk);
        chk("drop_still_req", 128'(bus_reqcyc), 128'(1));
        step();
        bus_respcyc = 1'b1;
        p1_respack  = 1'b1;
        @(negedge clk);
        chk("drop_back_idle", 128'(bus_reqcyc),  128'(0));
        chk("drop_no_beat",   128'(p1_respcyc),  128'(0));
        chk("drop_respack",   128'(bus_respack), 128'(0));
        bus_respcyc = 1'b0;
        p1_respack  = 1'b0;
        step();
        raise(0);
        raise(1);
        drain();

        // Owner withholds its beat acknowledge for 3 cycles at beat 2.
        step();
        raise(0);
        serve(0, 0, 2, 3, -1);

        // Reset during beat 4, then a clean transaction on port 1.
        step();
        raise(0);
        serve(0, 1, -1, 0, 4);
        step();
        raise(1);
        serve(1, 0, -1, 0, -1);

        // Randomized traffic; a waiting loser carries over to the next round.
        for (int k = 0; k < 30; k++) begin
            int mask;
            if (!p0_reqcyc && !p1_reqcyc) repeat ($urandom_range(2)) step();
            mask = int'($urandom_range(1, 3));
            if ((mask & 1) != 0 && !p0_reqcyc) raise(0);
            if ((mask & 2) != 0 && !p1_reqcyc) raise(1);
            serve(model_grant(p0_reqcyc, p1_reqcyc), int'($urandom_range(3)),
                  ($urandom_range(1) != 0) ? int'($urandom_range(BEATS - 1)) : -1,
                  int'($urandom_range(3)), -1);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
